// File: rtl/img_bram_uart_tx.sv
// img_bram_uart_tx
//
// Reads a WIDTH x HEIGHT greyscale image out of a read-first BRAM in raster
// order and serialises it over UART 8N1 (start bit, 8 data bits LSB first,
// stop bit). Each bit is held for CLOCKS_PER_BAUD cycles. Consecutive bytes
// follow each other with no idle gap. The next pixel is fetched during the
// stop bit of the current byte.
//
// Optional feature, enabled by defining IMG_TX_HEADER_EN:
//   Three header bytes are sent before the pixels: 0xA5, WIDTH[7:0] and
//   HEIGHT[7:0]. No BRAM read happens for these bytes. Pixel 0 is prefetched
//   during the stop bit of the third header byte.
//
// Ports:
//   clk_in     system clock
//   rst_in     synchronous active-high reset
//   start_in   one-cycle request to send the whole image (accepted only in IDLE)
//   pixel_in   BRAM read data, valid BRAM_LATENCY cycles after rd_en_out
//   addr_out   BRAM read address
//   rd_en_out  BRAM port enable, a one-cycle pulse per pixel
//   tx_out     UART serial line, idles high
//   busy_out   high while a frame is in progress
//   done_out   one-cycle pulse after the last stop bit
//
// Parameters:
//   CLOCKS_PER_BAUD  must be greater than BRAM_LATENCY+1
//   BIT_DEPTH        must be 8

module img_bram_uart_tx #(
    parameter int CLOCKS_PER_BAUD = 50,
    parameter int WIDTH           = 32,
    parameter int HEIGHT          = 32,
    parameter int BIT_DEPTH       = 8,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start_in,
    input  logic [BIT_DEPTH-1:0]              pixel_in,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
    output logic                              rd_en_out,
    output logic                              tx_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int ADDR_W = $clog2(WIDTH*HEIGHT);
    localparam int CNT_W  = $clog2(CLOCKS_PER_BAUD);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT - 1);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0]  LAT_CNT   = CNT_W'(BRAM_LATENCY);
    localparam logic [2:0]        BIT_LAST  = 3'(BIT_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       baud_q;
    logic [2:0]             bit_q;
    logic [BIT_DEPTH-1:0]   shreg_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   more_q;
    logic                   fetch_q;
    logic                   done_q;
    logic                   baud_end;
    logic                   fetch_end;

`ifdef IMG_TX_HEADER_EN
    localparam logic [7:0] HDR_SYNC   = 8'hA5;
    localparam logic [7:0] HDR_WIDTH  = 8'(WIDTH);
    localparam logic [7:0] HDR_HEIGHT = 8'(HEIGHT);

    logic       in_hdr_q;
    logic [1:0] hdr_idx_q;

    // The first header byte is loaded on the start request, so FETCH is just
    // a single cycle.
    assign fetch_end = 1'b1;
`else
    // The pixel appears on pixel_in BRAM_LATENCY cycles after the FETCH issue cycle.
    assign fetch_end = (baud_q == LAT_CNT);
`endif

    assign baud_end = (baud_q == BAUD_LAST);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A start request during the done pulse is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in && !done_q)        state_d = FETCH;
            FETCH:   if (fetch_end)                  state_d = START;
            START:   if (baud_end)                   state_d = DATA;
            DATA:    if (baud_end && bit_q == BIT_LAST) state_d = STOP;
            STOP:    if (baud_end)                   state_d = more_q ? START : IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // Output logic. All outputs come from registered state only.
    always_comb begin
        tx_out    = 1'b1;
        busy_out  = (state_q != IDLE);
        done_out  = done_q;
        addr_out  = addr_q;
        rd_en_out = 1'b0;
        case (state_q)
            FETCH: begin
`ifndef IMG_TX_HEADER_EN
                rd_en_out = (baud_q == '0);
`endif
            end
            START:   tx_out = 1'b0;
            DATA:    tx_out = shreg_q[0];
            STOP:    rd_en_out = fetch_q && (baud_q == '0);
            default: ;
        endcase
    end

    // Datapath: baud/bit counters, shift register and address sequencing.
    // When a byte's last data bit ends, the controller decides two things: whether
    // another byte follows (more_q), and whether the stop bit must read the BRAM
    // (fetch_q). The stop bit is long enough to cover the read latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            addr_q    <= '0;
            more_q    <= 1'b0;
            fetch_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef IMG_TX_HEADER_EN
            in_hdr_q  <= 1'b0;
            hdr_idx_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q  <= '0;
                    bit_q   <= '0;
                    fetch_q <= 1'b0;
`ifdef IMG_TX_HEADER_EN
                    if (start_in && !done_q) begin
                        in_hdr_q  <= 1'b1;
                        hdr_idx_q <= '0;
                        shreg_q   <= HDR_SYNC;
                    end
`endif
                end

                FETCH: begin
                    if (fetch_end) begin
                        baud_q <= '0;
`ifndef IMG_TX_HEADER_EN
                        shreg_q <= pixel_in;
`endif
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                START: begin
                    baud_q <= baud_end ? '0 : baud_q + 1'b1;
                end

                DATA: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
`ifdef IMG_TX_HEADER_EN
                            if (in_hdr_q) begin
                                more_q    <= 1'b1;
                                hdr_idx_q <= hdr_idx_q + 1'b1;
                                if (hdr_idx_q == 2'd2) begin
                                    // Address 0 is already on addr_q.
                                    in_hdr_q <= 1'b0;
                                    fetch_q  <= 1'b1;
                                end else begin
                                    fetch_q <= 1'b0;
                                    shreg_q <= (hdr_idx_q == 2'd0) ? HDR_WIDTH : HDR_HEIGHT;
                                end
                            end else
`endif
                            begin
                                more_q  <= (addr_q != LAST_ADDR);
                                fetch_q <= (addr_q != LAST_ADDR);
                                if (addr_q != LAST_ADDR) begin
                                    addr_q <= addr_q + 1'b1;
                                end
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                STOP: begin
                    if (fetch_q && baud_q == LAT_CNT) begin
                        shreg_q <= pixel_in;
                    end
                    if (baud_end) begin
                        baud_q  <= '0;
                        fetch_q <= 1'b0;
                        if (!more_q) begin
                            addr_q <= '0;
                            done_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_bram_uart_tx.sv
// tb_img_bram_uart_tx
//
// Bench for img_bram_uart_tx with a 4x2 image, 8 clocks per baud and a
// two-cycle BRAM model. Each frame is captured cycle by cycle. The capture is
// then compared with a reference built from the byte stream the frame should
// carry. The reference covers the line waveform, the decoded bytes, the done
// and busy timing, and the BRAM read schedule. Defining IMG_TX_HEADER_EN
// selects the header variant of the expectations.

module tb_img_bram_uart_tx;

    localparam int W        = 4;
    localparam int H        = 2;
    localparam int CPB      = 8;
    localparam int LAT      = 2;
    localparam int NPIX     = W * H;
    localparam int AW       = $clog2(NPIX);
`ifdef IMG_TX_HEADER_EN
    localparam int HDR      = 3;
    localparam int S0       = 2;
`else
    localparam int HDR      = 0;
    localparam int S0       = 4;
`endif
    localparam int NB       = NPIX + HDR;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int DONE_T   = S0 + BYTE_CYC * NB;
    localparam int NCAP     = DONE_T + 40;

    typedef struct packed {
        int fall;
        int nbytes;
        int byte_err;
        int tx_err;
        int ndone;
        int done_t;
        int busy_err;
        int npulse;
        int rd_err;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [7:0]    pixel_in;
    logic [AW-1:0] addr_out;
    logic          rd_en_out;
    logic          tx_out;
    logic          busy_out;
    logic          done_out;

    logic [7:0]    mem [0:NPIX-1];
    logic [7:0]    r1;
    logic          v1;

    logic          cap_tx   [0:NCAP];
    logic          cap_busy [0:NCAP];
    logic          cap_done [0:NCAP];
    logic          cap_rd   [0:NCAP];
    logic [AW-1:0] cap_addr [0:NCAP];

    logic [7:0]    exp_bytes [0:NB-1];
    logic [7:0]    dec_q [$];

    int n_vec = 0;
    int n_err = 0;

    img_bram_uart_tx #(
        .CLOCKS_PER_BAUD(CPB),
        .WIDTH(W),
        .HEIGHT(H),
        .BIT_DEPTH(8),
        .BRAM_LATENCY(LAT)
    ) dut (
        .clk_in(clk),
        .rst_in(rst_in),
        .start_in(start_in),
        .pixel_in(pixel_in),
        .addr_out(addr_out),
        .rd_en_out(rd_en_out),
        .tx_out(tx_out),
        .busy_out(busy_out),
        .done_out(done_out)
    );

    always #5 clk = ~clk;

    // BRAM with an output register. The requested byte is on pixel_in only in
    // the single cycle it becomes due. Every other cycle carries random junk.
    // A sample taken on the wrong cycle therefore corrupts the stream.
    always @(posedge clk) begin
        v1 <= rd_en_out;
        if (rd_en_out) r1 <= mem[addr_out];
        pixel_in <= v1 ? r1 : 8'($urandom);
    end

    function automatic void build_expected();
`ifdef IMG_TX_HEADER_EN
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = 8'(W);
        exp_bytes[2] = 8'(H);
`endif
        for (int i = 0; i < NPIX; i++) exp_bytes[HDR + i] = mem[i];
    endfunction

    // Ideal line level at cycle t of a frame that starts in cycle 0.
    function automatic logic exp_tx(input int t);
        int k, b, pos;
        if (t < S0) return 1'b1;
        k   = (t - S0) / CPB;
        b   = k / 10;
        pos = k % 10;
        if (b >= NB)   return 1'b1;
        if (pos == 0)  return 1'b0;
        if (pos == 9)  return 1'b1;
        return exp_bytes[b][pos - 1];
    endfunction

    // Pixel 0 is read straight after the start request, or during the last
    // header stop bit. Every other pixel is read in the first cycle of the
    // previous byte's stop bit.
    function automatic int issue_cycle(input int p);
        if (HDR + p == 0) return 1;
        return S0 + BYTE_CYC * (HDR + p - 1) + 9 * CPB;
    endfunction

    function automatic int pixel_issued_at(input int t);
        for (int p = 0; p < NPIX; p++) if (issue_cycle(p) == t) return p;
        return -1;
    endfunction

    function automatic frame_t analyse(input int upto);
        frame_t f;
        logic [7:0] b;
        int t, mid, ip;
        f = '0;
        f.fall = -1;
        f.done_t = -1;
        dec_q.delete();
        t = 1;
        while (t <= upto) begin
            if (cap_tx[t] == 1'b0 && cap_tx[t - 1] == 1'b1) begin
                if (f.fall < 0) f.fall = t;
                mid = t + CPB / 2;
                if (mid + 9 * CPB > upto) break;
                for (int i = 0; i < 8; i++) b[i] = cap_tx[mid + (i + 1) * CPB];
                dec_q.push_back(b);
                t = mid + 9 * CPB;
            end else begin
                t++;
            end
        end
        f.nbytes = dec_q.size();
        for (int i = 0; i < dec_q.size() && i < NB; i++)
            if (dec_q[i] !== exp_bytes[i]) f.byte_err++;
        for (int c = 1; c <= upto; c++) begin
            if (cap_tx[c] !== exp_tx(c)) f.tx_err++;
            if (cap_done[c] === 1'b1) begin
                f.ndone++;
                if (f.done_t < 0) f.done_t = c;
            end
            if (cap_busy[c] !== (c < DONE_T)) f.busy_err++;
            if (cap_rd[c] === 1'b1) f.npulse++;
            ip = pixel_issued_at(c);
            if ((ip >= 0) !== cap_rd[c]) f.rd_err++;
            else if (ip >= 0 && cap_addr[c] !== AW'(ip)) f.rd_err++;
        end
        return f;
    endfunction

    // Issues start_in in cycle 0 and records cycles 1..NCAP. It optionally
    // raises start_in or rst_in for one cycle at a chosen cycle.
    task automatic capture(input int mid_start, input int rst_at);
        @(negedge clk);
        start_in = 1'b1;
        cap_tx[0] = tx_out;
        cap_busy[0] = busy_out;
        cap_done[0] = done_out;
        cap_rd[0] = rd_en_out;
        cap_addr[0] = addr_out;
        for (int t = 1; t <= NCAP; t++) begin
            @(negedge clk);
            cap_tx[t]   = tx_out;
            cap_busy[t] = busy_out;
            cap_done[t] = done_out;
            cap_rd[t]   = rd_en_out;
            cap_addr[t] = addr_out;
            start_in = (t == mid_start);
            rst_in   = (t == rst_at);
        end
        start_in = 1'b0;
        rst_in   = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        start_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        n_vec++; if (tx_out !== 1'b1)   begin n_err++; $display("[TB] FAIL reset_tx: got %b expected 1", tx_out); end
        n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_out); end
        n_vec++; if (done_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b expected 0", done_out); end
        n_vec++; if (addr_out !== '0)   begin n_err++; $display("[TB] FAIL reset_addr: got %0d expected 0", addr_out); end
        n_vec++; if (rd_en_out !== 1'b0) begin n_err++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en_out); end
    endtask

    task automatic test_basic_frame();
        frame_t f;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        build_expected();
        capture(-1, -1);
        f = analyse(NCAP);
        n_vec++; if (f.fall != S0) begin n_err++; $display("[TB] FAIL basic_first_fall: got %0d expected %0d", f.fall, S0); end
        n_vec++; if (f.nbytes != NB) begin n_err++; $display("[TB] FAIL basic_byte_count: got %0d expected %0d", f.nbytes, NB); end
        for (int i = 0; i < dec_q.size() && i < NB; i++) begin
            n_vec++;
            if (dec_q[i] !== exp_bytes[i]) begin
                n_err++;
                $display("[TB] FAIL basic_byte%0d: got %02h expected %02h", i, dec_q[i], exp_bytes[i]);
            end
        end
        n_vec++; if (f.tx_err != 0) begin n_err++; $display("[TB] FAIL basic_waveform: got %0d bad cycles expected 0", f.tx_err); end
        n_vec++; if (f.ndone != 1) begin n_err++; $display("[TB] FAIL basic_done_count: got %0d expected 1", f.ndone); end
        n_vec++; if (f.done_t != DONE_T) begin n_err++; $display("[TB] FAIL basic_done_cycle: got %0d expected %0d", f.done_t, DONE_T); end
        n_vec++; if (f.busy_err != 0) begin n_err++; $display("[TB] FAIL basic_busy_window: got %0d bad cycles expected 0", f.busy_err); end
        n_vec++; if (f.npulse != NPIX) begin n_err++; $display("[TB] FAIL basic_rd_en_pulses: got %0d expected %0d", f.npulse, NPIX); end
        n_vec++; if (f.rd_err != 0) begin n_err++; $display("[TB] FAIL basic_rd_schedule: got %0d bad cycles expected 0", f.rd_err); end
    endtask

    task automatic test_pattern_5a();
        frame_t f;
        logic [9:0] line_bits;
        int base, bad;
        line_bits = 10'b1010110100;
        fill_random();
        mem[0] = 8'h5A;
        build_expected();
        capture(-1, -1);
        base = S0 + HDR * BYTE_CYC;
        for (int k = 0; k < 10; k++) begin
            bad = 0;
            for (int j = 0; j < CPB; j++)
                if (cap_tx[base + k * CPB + j] !== line_bits[k]) bad++;
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("[TB] FAIL pattern_5a_bit%0d: got %0d wrong cycles expected 0 (level %b)", k, bad, line_bits[k]);
            end
        end
        f = analyse(NCAP);
        n_vec++; if (f.tx_err != 0) begin n_err++; $display("[TB] FAIL pattern_waveform: got %0d bad cycles expected 0", f.tx_err); end
        n_vec++; if (f.byte_err != 0 || f.nbytes != NB) begin n_err++; $display("[TB] FAIL pattern_bytes: got %0d bytes/%0d wrong expected %0d/0", f.nbytes, f.byte_err, NB); end
    endtask

    task automatic test_mid_start();
        frame_t f;
        fill_random();
        build_expected();
        capture(S0 + 3 * BYTE_CYC + 20, -1);
        f = analyse(NCAP);
        n_vec++; if (f.nbytes != NB || f.byte_err != 0) begin n_err++; $display("[TB] FAIL midstart_bytes: got %0d bytes/%0d wrong expected %0d/0", f.nbytes, f.byte_err, NB); end
        n_vec++; if (f.ndone != 1) begin n_err++; $display("[TB] FAIL midstart_done_count: got %0d expected 1", f.ndone); end
        n_vec++; if (f.rd_err != 0) begin n_err++; $display("[TB] FAIL midstart_rd_schedule: got %0d bad cycles expected 0", f.rd_err); end
        n_vec++; if (f.busy_err != 0) begin n_err++; $display("[TB] FAIL midstart_busy: got %0d bad cycles expected 0", f.busy_err); end
    endtask

    task automatic test_back_to_back();
        frame_t f;
        fill_random();
        build_expected();
        capture(DONE_T, -1);
        f = analyse(NCAP);
        n_vec++; if (f.busy_err != 0) begin n_err++; $display("[TB] FAIL start_on_done_busy: got %0d bad cycles expected 0", f.busy_err); end
        n_vec++; if (f.npulse != NPIX) begin n_err++; $display("[TB] FAIL start_on_done_pulses: got %0d expected %0d", f.npulse, NPIX); end
        n_vec++; if (f.ndone != 1) begin n_err++; $display("[TB] FAIL start_on_done_count: got %0d expected 1", f.ndone); end
        n_vec++; if (f.tx_err != 0) begin n_err++; $display("[TB] FAIL start_on_done_waveform: got %0d bad cycles expected 0", f.tx_err); end
    endtask

    task automatic test_reset_mid();
        frame_t f;
        int rst_at, bad_tx, bad_busy, ndone;
        rst_at = S0 + 2 * BYTE_CYC + 3 * CPB + 2;
        fill_random();
        build_expected();
        capture(-1, rst_at);
        bad_tx = 0;
        for (int t = 1; t <= rst_at; t++) if (cap_tx[t] !== exp_tx(t)) bad_tx++;
        bad_busy = 0;
        ndone = 0;
        for (int t = rst_at + 1; t <= NCAP; t++) if (cap_busy[t] !== 1'b0) bad_busy++;
        for (int t = 1; t <= NCAP; t++) if (cap_done[t] === 1'b1) ndone++;
        n_vec++; if (bad_tx != 0) begin n_err++; $display("[TB] FAIL rstmid_pre_waveform: got %0d bad cycles expected 0", bad_tx); end
        n_vec++; if (cap_tx[rst_at + 1] !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid_tx: got %b expected 1", cap_tx[rst_at + 1]); end
        n_vec++; if (cap_busy[rst_at + 1] !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_busy: got %b expected 0", cap_busy[rst_at + 1]); end
        n_vec++; if (cap_addr[rst_at + 1] !== '0) begin n_err++; $display("[TB] FAIL rstmid_addr: got %0d expected 0", cap_addr[rst_at + 1]); end
        n_vec++; if (bad_busy != 0) begin n_err++; $display("[TB] FAIL rstmid_stays_idle: got %0d busy cycles expected 0", bad_busy); end
        n_vec++; if (ndone != 0) begin n_err++; $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", ndone); end
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        build_expected();
        capture(-1, -1);
        f = analyse(NCAP);
        n_vec++; if (f.nbytes != NB || f.byte_err != 0) begin n_err++; $display("[TB] FAIL rstmid_refresh_bytes: got %0d bytes/%0d wrong expected %0d/0", f.nbytes, f.byte_err, NB); end
        n_vec++; if (f.ndone != 1 || f.done_t != DONE_T) begin n_err++; $display("[TB] FAIL rstmid_refresh_done: got %0d at %0d expected 1 at %0d", f.ndone, f.done_t, DONE_T); end
    endtask

    initial begin
        rst_in = 1'b1;
        start_in = 1'b0;
        $display("[TB] img_bram_uart_tx bench: W=%0d H=%0d CPB=%0d header_bytes=%0d", W, H, CPB, HDR);
        test_reset();
        test_basic_frame();
        test_pattern_5a();
        test_mid_start();
        test_back_to_back();
        test_reset_mid();
        for (int r = 0; r < 2; r++) test_mid_start();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
